// File: rtl/commit_monitor.sv
// Retire-side trace FIFO, commit statistics and PC sanity flags for the write-back commit port.
// Optional redirect tracking is built when COMMIT_MON_REDIRECT_EN is defined.
module commit_monitor #(
  parameter int unsigned PC_WIDTH  = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     commit_i,
  input  logic [PC_WIDTH-1:0]      commit_pc_i,
  input  logic [PC_WIDTH-1:0]      commit_pre_pc_i,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic [PC_WIDTH-1:0]      trace_pc_o,
  output logic [PC_WIDTH-1:0]      trace_npc_o,
  output logic [CNT_WIDTH-1:0]     trace_seq_o,
  output logic                     trace_redirect_o,
  output logic [CNT_WIDTH-1:0]     retired_cnt_o,
  output logic [CNT_WIDTH-1:0]     cycle_cnt_o,
  output logic [CNT_WIDTH-1:0]     redirect_cnt_o,
  output logic [CNT_WIDTH-1:0]     drop_cnt_o,
  output logic                     overflow_o,
  output logic                     misalign_o,
  output logic [PC_WIDTH-1:0]      misalign_pc_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef struct packed {
    logic [PC_WIDTH-1:0]  pc;
    logic [PC_WIDTH-1:0]  npc;
    logic [CNT_WIDTH-1:0] seq;
`ifdef COMMIT_MON_REDIRECT_EN
    logic                 redirect;
`endif
  } rec_t;

  rec_t          mem_q [DEPTH];
  rec_t          head_c;
  rec_t          wr_rec_c;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          full_c;
  logic          pop_c;
  logic          push_c;
  logic          drop_c;
  logic          misalign_hit_c;

  assign full_c         = (level_q == LW'(DEPTH));
  assign pop_c          = trace_valid_o && trace_ready_i;
  assign push_c         = commit_i && (!full_c || pop_c);
  assign drop_c         = commit_i && full_c && !pop_c;
  assign misalign_hit_c = commit_i && (commit_pc_i[1:0] != 2'b00) && !misalign_o;

`ifdef COMMIT_MON_REDIRECT_EN
  typedef enum logic {FIRST, TRACK} state_t;

  state_t              state_q;
  state_t              state_d;
  logic [PC_WIDTH-1:0] exp_pc_q;
  logic [PC_WIDTH-1:0] exp_pc_d;
  logic                redirect_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= FIRST;
      exp_pc_q       <= '0;
      redirect_cnt_o <= '0;
    end else begin
      state_q  <= state_d;
      exp_pc_q <= exp_pc_d;
      if (redirect_c) redirect_cnt_o <= redirect_cnt_o + CNT_WIDTH'(1);
    end
  end

  // The first commit after reset only seeds the expected PC; it cannot be a redirect.
  always_comb begin
    state_d    = state_q;
    exp_pc_d   = exp_pc_q;
    redirect_c = 1'b0;
    case (state_q)
      FIRST: if (commit_i) begin
        state_d  = TRACK;
        exp_pc_d = commit_pre_pc_i;
      end
      TRACK: if (commit_i) begin
        redirect_c = (commit_pc_i != exp_pc_q);
        exp_pc_d   = commit_pre_pc_i;
      end
    endcase
  end

  assign wr_rec_c         = '{pc: commit_pc_i, npc: commit_pre_pc_i, seq: retired_cnt_o, redirect: redirect_c};
  assign trace_redirect_o = trace_valid_o ? head_c.redirect : 1'b0;
`else
  assign wr_rec_c         = '{pc: commit_pc_i, npc: commit_pre_pc_i, seq: retired_cnt_o};
  assign trace_redirect_o = 1'b0;
  assign redirect_cnt_o   = '0;
`endif

  // Storage is not reset; the head fields are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= wr_rec_c;
  end

  assign head_c        = mem_q[rd_ptr_q];
  assign trace_valid_o = (level_q != '0);
  assign trace_pc_o    = trace_valid_o ? head_c.pc  : '0;
  assign trace_npc_o   = trace_valid_o ? head_c.npc : '0;
  assign trace_seq_o   = trace_valid_o ? head_c.seq : '0;
  assign level_o       = level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_c, pop_c})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Statistics and sticky flags update on the edge that samples the commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt_o <= '0;
      cycle_cnt_o   <= '0;
      drop_cnt_o    <= '0;
      overflow_o    <= 1'b0;
      misalign_o    <= 1'b0;
      misalign_pc_o <= '0;
    end else begin
      cycle_cnt_o <= cycle_cnt_o + CNT_WIDTH'(1);
      if (commit_i) retired_cnt_o <= retired_cnt_o + CNT_WIDTH'(1);
      if (drop_c) begin
        drop_cnt_o <= drop_cnt_o + CNT_WIDTH'(1);
        overflow_o <= 1'b1;
      end
      if (misalign_hit_c) begin
        misalign_o    <= 1'b1;
        misalign_pc_o <= commit_pc_i;
      end
    end
  end

endmodule

// File: tb/tb_commit_monitor.sv
// Directed and randomized bench for commit_monitor against a queue-based reference model.
module tb_commit_monitor;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        commit_i = 1'b0;
  logic [31:0] commit_pc_i = '0;
  logic [31:0] commit_pre_pc_i = '0;
  logic        trace_valid_o;
  logic        trace_ready_i = 1'b0;
  logic [31:0] trace_pc_o;
  logic [31:0] trace_npc_o;
  logic [31:0] trace_seq_o;
  logic        trace_redirect_o;
  logic [31:0] retired_cnt_o;
  logic [31:0] cycle_cnt_o;
  logic [31:0] redirect_cnt_o;
  logic [31:0] drop_cnt_o;
  logic        overflow_o;
  logic        misalign_o;
  logic [31:0] misalign_pc_o;
  logic [3:0]  level_o;

  commit_monitor #(.PC_WIDTH(32), .DEPTH(DEPTH), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .commit_i(commit_i), .commit_pc_i(commit_pc_i), .commit_pre_pc_i(commit_pre_pc_i),
    .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
    .trace_pc_o(trace_pc_o), .trace_npc_o(trace_npc_o), .trace_seq_o(trace_seq_o),
    .trace_redirect_o(trace_redirect_o),
    .retired_cnt_o(retired_cnt_o), .cycle_cnt_o(cycle_cnt_o),
    .redirect_cnt_o(redirect_cnt_o), .drop_cnt_o(drop_cnt_o),
    .overflow_o(overflow_o), .misalign_o(misalign_o), .misalign_pc_o(misalign_pc_o),
    .level_o(level_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] seq;
    logic        redir;
  } rec_t;

  rec_t        q[$];
  int unsigned m_ret, m_cyc, m_redir, m_drop;
  bit          m_ovf, m_mis, m_have_exp;
  logic [31:0] m_mis_pc, m_exp;

  int checks = 0;
  int errors = 0;

`ifdef COMMIT_MON_REDIRECT_EN
  localparam bit REDIR_ON = 1'b1;
`else
  localparam bit REDIR_ON = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ret = 0; m_cyc = 0; m_redir = 0; m_drop = 0;
    m_ovf = 0; m_mis = 0; m_have_exp = 0;
    m_mis_pc = '0; m_exp = '0;
  endtask

  task automatic check_all();
    check("valid", 64'(trace_valid_o), 64'(q.size() != 0));
    check("level", 64'(level_o), 64'(q.size()));
    if (q.size() != 0) begin
      check("head_pc", 64'(trace_pc_o), 64'(q[0].pc));
      check("head_npc", 64'(trace_npc_o), 64'(q[0].npc));
      check("head_seq", 64'(trace_seq_o), 64'(q[0].seq));
      check("head_redirect", 64'(trace_redirect_o), 64'(q[0].redir));
    end
    check("retired_cnt", 64'(retired_cnt_o), 64'(m_ret));
    check("cycle_cnt", 64'(cycle_cnt_o), 64'(m_cyc));
    check("redirect_cnt", 64'(redirect_cnt_o), 64'(m_redir));
    check("drop_cnt", 64'(drop_cnt_o), 64'(m_drop));
    check("overflow", 64'(overflow_o), 64'(m_ovf));
    check("misalign", 64'(misalign_o), 64'(m_mis));
    check("misalign_pc", 64'(misalign_pc_o), 64'(m_mis_pc));
  endtask

  // One clock: drive inputs, advance the model by the commit/retire rules, compare after the edge.
  task automatic step(input bit c, input logic [31:0] pc, input logic [31:0] npc, input bit rdy);
    bit pop, full, red;
    @(negedge clk);
    rst = 1'b0;
    commit_i = c; commit_pc_i = pc; commit_pre_pc_i = npc; trace_ready_i = rdy;
    m_cyc++;
    pop  = (q.size() != 0) && rdy;
    full = (q.size() == DEPTH);
    red  = 1'b0;
    if (c) begin
      if (REDIR_ON && m_have_exp && pc != m_exp) red = 1'b1;
      m_have_exp = 1'b1;
      m_exp = npc;
      if (red) m_redir++;
      if (pc[1:0] != 2'b00 && !m_mis) begin m_mis = 1'b1; m_mis_pc = pc; end
    end
    if (pop) void'(q.pop_front());
    if (c) begin
      if (!full || pop) q.push_back('{pc: pc, npc: npc, seq: m_ret, redir: red});
      else begin m_drop++; m_ovf = 1'b1; end
      m_ret++;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; commit_i = 1'b0; trace_ready_i = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check("rst_valid", 64'(trace_valid_o), 64'd0);
    check("rst_pc", 64'(trace_pc_o), 64'd0);
    check("rst_npc", 64'(trace_npc_o), 64'd0);
    check("rst_seq", 64'(trace_seq_o), 64'd0);
    check("rst_redirect", 64'(trace_redirect_o), 64'd0);
    check_all();
  endtask

  initial begin
    logic [31:0] cur_pc, pc, npc;
    bit c, rdy;

    model_reset();
    do_reset();

    // Sequential stream with ready held high.
    step(1, 32'h0, 32'h4, 1);
    step(1, 32'h4, 32'h8, 1);
    step(1, 32'h8, 32'hC, 1);
    check("seq_retired3", 64'(retired_cnt_o), 64'd3);
    for (int i = 0; i < 3; i++) step(0, '0, '0, 1);

    // Redirect: second commit breaks the predicted flow.
    do_reset();
    step(1, 32'h10, 32'h14, 0);
    step(1, 32'h40, 32'h44, 0);
    step(0, '0, '0, 1);
    check("redir_head_pc", 64'(trace_pc_o), 64'h40);
    check("redir_bit", 64'(trace_redirect_o), 64'(REDIR_ON));
    check("redir_cnt", 64'(redirect_cnt_o), 64'(REDIR_ON));
    step(0, '0, '0, 1);

    // Overflow with ready low, then a push and pop on a full FIFO.
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 32'(4 * i), 32'(4 * i + 4), 0);
    check("ovf_level", 64'(level_o), 64'd8);
    check("ovf_drop", 64'(drop_cnt_o), 64'd2);
    check("ovf_flag", 64'(overflow_o), 64'd1);
    check("ovf_retired", 64'(retired_cnt_o), 64'd10);
    check("ovf_head_seq", 64'(trace_seq_o), 64'd0);
    step(1, 32'h28, 32'h2C, 1);
    check("full_pp_drop", 64'(drop_cnt_o), 64'd2);
    check("full_pp_level", 64'(level_o), 64'd8);
    check("full_pp_seq", 64'(trace_seq_o), 64'd1);

    // Backpressure: ready 1,0,0,1 with four records queued, then drain.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 32'(32'h100 + 4 * i), 32'(32'h104 + 4 * i), 0);
    step(0, '0, '0, 1);
    step(0, '0, '0, 0);
    check("bp_hold_seq", 64'(trace_seq_o), 64'd1);
    step(0, '0, '0, 0);
    check("bp_hold_pc", 64'(trace_pc_o), 64'h104);
    step(0, '0, '0, 1);
    for (int i = 0; i < 3; i++) step(0, '0, '0, 1);
    check("bp_drained", 64'(level_o), 64'd0);

    // Misalign capture, then reset clears everything.
    do_reset();
    step(1, 32'h22, 32'h26, 0);
    step(1, 32'h31, 32'h35, 0);
    check("mis_pc_first", 64'(misalign_pc_o), 64'h22);
    do_reset();
    step(0, '0, '0, 1);
    step(0, '0, '0, 1);
    check("post_rst_valid", 64'(trace_valid_o), 64'd0);

    // Randomized traffic with mispredicts, occasional misaligned PCs and random backpressure.
    do_reset();
    cur_pc = 32'h1000;
    for (int i = 0; i < 600; i++) begin
      c   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      pc  = ($urandom_range(0, 40) == 0) ? (cur_pc | 32'h1) : cur_pc;
      npc = ($urandom_range(0, 7) == 0) ? ($urandom() & 32'hFFFF_FFFC) : pc + 32'd4;
      step(c, pc, npc, rdy);
      if (c) cur_pc = ($urandom_range(0, 5) == 0) ? ($urandom() & 32'hFFFF_FFFC) : (npc & 32'hFFFF_FFFC);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/commit_monitor.md
# commit_monitor

Retire-side trace and statistics block that sits directly downstream of the CPU's write-back commit outputs (`commit`, `commit_pc`, `commit_pre_pc`). Every committed instruction is captured into a small FIFO as a sequenced trace record, drained over a valid/ready port toward a testbench scoreboard or debug UART. In parallel the block keeps retired-instruction and cycle counters, detects control-flow redirects, and flags overflow and misaligned PCs.

## Interface
- `PC_WIDTH`, 32: width of PC fields.
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `CNT_WIDTH`, 32: width of all counters and the sequence number.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `commit_i` in 1: an instruction retires this cycle.
- `commit_pc_i` in PC_WIDTH: PC of the retiring instruction.
- `commit_pre_pc_i` in PC_WIDTH: next PC predicted at fetch for the retiring instruction.
- `trace_valid_o` out 1: head record is available.
- `trace_ready_i` in 1: consumer accepts the head record.
- `trace_pc_o` out PC_WIDTH: head record PC.
- `trace_npc_o` out PC_WIDTH: head record predicted next PC.
- `trace_seq_o` out CNT_WIDTH: head record sequence number, starting at 0.
- `trace_redirect_o` out 1: head record followed a redirect.
- `retired_cnt_o` out CNT_WIDTH: commits seen, including dropped commits.
- `cycle_cnt_o` out CNT_WIDTH: cycles since reset.
- `redirect_cnt_o` out CNT_WIDTH: redirects detected.
- `drop_cnt_o` out CNT_WIDTH: records dropped because the FIFO was full.
- `overflow_o` out 1: sticky; at least one record was dropped.
- `misalign_o` out 1: sticky; a committed PC had `pc[1:0] != 0`.
- `misalign_pc_o` out PC_WIDTH: first misaligned PC seen.
- `level_o` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- Tracking state machine:
  - States are FIRST and TRACK. Reset enters FIRST.
  - On the first `commit_i`, move to TRACK and latch `commit_pre_pc_i` into `exp_pc`.
  - In TRACK, each `commit_i` compares `commit_pc_i` with `exp_pc`. Inequality is a redirect. `exp_pc` is then updated to `commit_pre_pc_i`.
  - A commit taken in FIRST is never a redirect.
- Push:
  - When `commit_i` is high and the FIFO is not full, write `{commit_pc_i, commit_pre_pc_i, seq, redirect}` at the write pointer.
  - `seq` is `retired_cnt_o` before increment.
- Drop:
  - When `commit_i` is high and the FIFO is full, with no pop in the same cycle, the record is discarded.
  - `drop_cnt_o` increments and `overflow_o` is set.
  - `retired_cnt_o`, `seq` and redirect tracking still advance.
- Pop:
  - A pop occurs when `trace_valid_o` and `trace_ready_i` are both high; the read pointer advances.
  - Outputs are driven from the head entry (register array read).
  - `trace_valid_o` = (`level_o` != 0).
- Simultaneous push and pop:
  - When full, the push is accepted and `level_o` is unchanged.
  - When empty, the new record is not visible until the next cycle; no bypass.
- Pointers are log2(DEPTH) bits wide and wrap naturally.
- Misalignment: the first commit with `pc[1:0] != 0` sets `misalign_o` and captures `misalign_pc_o`. Later misaligned PCs do not overwrite the capture.
- Counters:
  - All counters wrap modulo 2^CNT_WIDTH.
  - `cycle_cnt_o` increments every cycle that is not in reset.
- Reset:
  - All outputs are 0, all counters 0, the FIFO is empty and the state is FIRST.
  - Reset mid-stream discards all queued records; no record is emitted afterwards.

## Timing
- Commit at edge N produces `trace_valid_o` high after edge N+1 if the FIFO was empty; latency is 1 cycle.
- Counters and sticky flags update on the same edge that samples the commit.
- With `trace_ready_i` held high, sustained throughput is 1 record per cycle.
- `trace_*` outputs must stay stable while `trace_valid_o` is high and `trace_ready_i` is low.
- `cycle_cnt_o` reads 1 after the first edge following reset release.

## Configuration
- `COMMIT_MON_REDIRECT_EN` defined:
  - The FIRST/TRACK machine, `exp_pc`, redirect detection, `redirect_cnt_o` and the redirect bit in the FIFO entry are built.
- `COMMIT_MON_REDIRECT_EN` undefined:
  - None of that logic is built.
  - `trace_redirect_o` and `redirect_cnt_o` are tied to 0.
  - The FIFO entry omits the redirect bit.
  - All other behaviour is identical.

## Test plan
- Sequential stream:
  - Stimulus: commits at PC 0x0, 0x4, 0x8 with pre_pc 0x4, 0x8, 0xC; ready held high.
  - Response: three records with seq 0, 1, 2; redirect bits all 0; `retired_cnt_o` = 3.
- Redirect (macro defined):
  - Stimulus: commit PC 0x10 with pre_pc 0x14, then commit PC 0x40.
  - Response: the second record has `trace_redirect_o` = 1; `redirect_cnt_o` = 1.
- Overflow (DEPTH = 8, ready held low):
  - Stimulus: 10 consecutive commits.
  - Response: `level_o` = 8; `drop_cnt_o` = 2; `overflow_o` = 1; `retired_cnt_o` = 10; head seq = 0.
- Full with simultaneous push and pop:
  - Stimulus: FIFO full; commit and ready high in the same cycle.
  - Response: no drop; `level_o` stays 8; head seq advances by 1.
- Backpressure:
  - Stimulus: ready toggled 1, 0, 0, 1 with 4 records queued.
  - Response: outputs hold steady during the stall; records are drained in order with no loss.
- Misalign then reset:
  - Stimulus: commit PC 0x22, then PC 0x31, then assert `rst` for 1 cycle.
  - Response before reset: `misalign_pc_o` = 0x22.
  - Response after reset: all outputs 0, `trace_valid_o` = 0, state FIRST.
